dbus_arbiter: RTL and testbench

- Arbitrates the shared data-bus memory port between three requesters: CPU DbLoad/DbStore (index 0), CCD capture writer (index 1) and NN accelerator (index 2).
- Grants one requester at a time for a burst of up to MAX_BURST beats.
- Muxes the winner's address, data and write enable onto the bus, and returns per-beat acknowledges.
- Produces a CPU stall so the pipeline holds while a CPU bus access is pending.

---
 rtl/dbus_arbiter_if.sv | 33 +++
 rtl/dbus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dbus_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_arbiter_if.sv
// Handshake bundle between the data-bus arbiter, its three requesters and the memory port.
// Arbiter side uses modport master; requester/memory side uses modport slave.
interface dbus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [2:0]          req;
    logic [2:0]          we;
    logic [2:0]          last;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt;
    logic [2:0]          ack;
    logic [DATA_W-1:0]   rdata;
    logic                err;
    logic                cpu_stall;
    logic                bus_req;
    logic                bus_we;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic                bus_ready;
    logic [DATA_W-1:0]   bus_rdata;

    modport master (
        input  req, we, last, addr, wdata, bus_ready, bus_rdata,
        output gnt, ack, rdata, err, cpu_stall, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output req, we, last, addr, wdata, bus_ready, bus_rdata,
        input  gnt, ack, rdata, err, cpu_stall, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/dbus_arbiter.sv
// Three-way data-bus arbiter (CPU=0, CCD=1, NN accelerator=2) with burst limit and beat timeout.
// Define DBUS_CPU_PRIORITY_EN to give the CPU absolute priority over the round robin.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no grant; pick a winner from req, grant appears next cycle
// ST_XFER | gnt one-hot to idx_q; beats muxed to the bus until release
module dbus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input logic            clk,
    input logic            rst_n,
    dbus_arbiter_if.master dbus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    state_e        state_q;
    logic [2:0]    gnt_q;
    logic [1:0]    idx_q;
    logic [1:0]    ptr_q;
    logic [BW-1:0] beat_q;
    logic [TW-1:0] tmo_q;

    logic          win_vld;
    logic [1:0]    win_idx;
    logic          xfer;
    logic          bus_req;
    logic          beat_done;
    logic          tmo_hit;
    logic          release_x;
    logic [BW-1:0] beat_inc;
    logic [2:0]    ack;
    logic          sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

`ifdef DBUS_CPU_PRIORITY_EN
    // CPU always wins; CCD and accelerator alternate through the pointer.
    always_comb begin
        win_vld = |dbus.req;
        win_idx = 2'd0;
        if (dbus.req[0])        win_idx = 2'd0;
        else if (ptr_q == 2'd2) win_idx = dbus.req[2] ? 2'd2 : 2'd1;
        else                    win_idx = dbus.req[1] ? 2'd1 : 2'd2;
    end
`else
    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    assign cand0 = ptr_q;
    assign cand1 = mod3_add(ptr_q, 2'd1);
    assign cand2 = mod3_add(ptr_q, 2'd2);

    always_comb begin
        win_vld = |dbus.req;
        win_idx = cand2;
        if (dbus.req[cand0])      win_idx = cand0;
        else if (dbus.req[cand1]) win_idx = cand1;
    end
`endif

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (idx_q)
            2'd0: begin
                sel_we    = dbus.we[0];
                sel_addr  = dbus.addr[0 +: ADDR_W];
                sel_wdata = dbus.wdata[0 +: DATA_W];
            end
            2'd1: begin
                sel_we    = dbus.we[1];
                sel_addr  = dbus.addr[ADDR_W +: ADDR_W];
                sel_wdata = dbus.wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                sel_we    = dbus.we[2];
                sel_addr  = dbus.addr[2*ADDR_W +: ADDR_W];
                sel_wdata = dbus.wdata[2*DATA_W +: DATA_W];
            end
            default: begin
                sel_we    = 1'b0;
                sel_addr  = '0;
                sel_wdata = '0;
            end
        endcase
    end

    assign xfer      = (state_q == ST_XFER);
    assign bus_req   = xfer & dbus.req[idx_q];
    assign beat_done = bus_req & dbus.bus_ready;
    // A ready arriving on the threshold cycle completes the beat instead of aborting.
    assign tmo_hit   = bus_req & ~dbus.bus_ready & (tmo_q == TW'(TIMEOUT));
    assign beat_inc  = beat_q + BW'(1);
    assign release_x = (beat_done & (dbus.last[idx_q] | (beat_inc == BW'(MAX_BURST))))
                     | ~dbus.req[idx_q]
                     | tmo_hit;
    assign ack       = beat_done ? gnt_q : 3'b000;

    assign dbus.gnt       = gnt_q;
    assign dbus.ack       = ack;
    assign dbus.rdata     = beat_done ? dbus.bus_rdata : '0;
    assign dbus.err       = tmo_hit;
    assign dbus.cpu_stall = dbus.req[0] & ~(gnt_q[0] & ack[0]);
    assign dbus.bus_req   = bus_req;
    assign dbus.bus_we    = bus_req & sel_we;
    assign dbus.bus_addr  = bus_req ? sel_addr : '0;
    assign dbus.bus_wdata = bus_req ? sel_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 3'b000;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
            beat_q  <= '0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        state_q <= ST_XFER;
                        idx_q   <= win_idx;
                        gnt_q   <= 3'b001 << win_idx;
                        beat_q  <= '0;
                        tmo_q   <= '0;
                    end
                end
                ST_XFER: begin
                    if (beat_done) begin
                        beat_q <= beat_inc;
                        tmo_q  <= '0;
                    end else if (bus_req && !tmo_hit) begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                    if (release_x) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= 3'b000;
                        ptr_q   <= mod3_add(idx_q, 2'd1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: requester agents and a memory responder drive directed scenarios;
// a transaction-level model predicts every output each cycle, literal expectations pin the model.
module tb_dbus_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MB = 16;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dbus ();

    dbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbus  (dbus)
    );

    int passed = 0;
    int total  = 0;

    // requester agents and memory responder
    int          rem[3];
    int          blen[3];
    int          bib[3];
    int          dcnt[3];
    logic [2:0]  we_cfg;
    logic [AW-1:0] abase[3];
    logic [DW-1:0] wbase[3];
    int          rdy_mode;
    int          rsp_wait;
    int          cyc;

    // observations recorded by the compare process
    logic [2:0]  ack_seen;
    logic [2:0]  err_gnt;
    logic [2:0]  gnt_prev;
    logic        breq_prev;
    int          grant_log[$];
    int          grant_cyc[$];
    int          ccd_runs[$];
    int          ccd_run;
    int          err_cnt;
    int          breq_rise;
    int          err_lat;
    int          ack_lat;

    // model state: who owns the bus, the round-robin start, beats served, wait cycles
    int          m_owner;
    int          m_rr;
    int          m_served;
    int          m_waited;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int pick(input int rr, input logic [2:0] r);
`ifdef DBUS_CPU_PRIORITY_EN
        if (r[0]) return 0;
        for (int k = 0; k < 3; k++) begin
            int c = (rr + k) % 3;
            if (c != 0 && r[c]) return c;
        end
`else
        for (int k = 0; k < 3; k++) begin
            int c = (rr + k) % 3;
            if (r[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 3; i++) begin
            dbus.req[i]               = (rem[i] > 0);
            dbus.last[i]              = (rem[i] == 1) || (bib[i] == blen[i] - 1);
            dbus.we[i]                = we_cfg[i];
            dbus.addr[i*AW +: AW]     = abase[i] + AW'(dcnt[i]);
            dbus.wdata[i*DW +: DW]    = wbase[i] + DW'(dcnt[i]);
        end
        case (rdy_mode)
            1:       dbus.bus_ready = 1'b0;
            2:       dbus.bus_ready = (rsp_wait >= 1);
            3:       dbus.bus_ready = (rsp_wait == TO);
            default: dbus.bus_ready = 1'b1;
        endcase
        dbus.bus_rdata = DW'(cyc * 37 + 5);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (ack_seen[i]) begin
                rem[i]--;
                dcnt[i]++;
                bib[i] = (bib[i] + 1 == blen[i]) ? 0 : bib[i] + 1;
            end
            if (err_gnt[i]) rem[i] = 0;
        end
        drive_inputs();
    endtask

    task automatic setup(input int i, input int n, input int bl, input logic w,
                         input logic [AW-1:0] ab, input logic [DW-1:0] wb);
        rem[i]   = n;
        blen[i]  = bl;
        bib[i]   = 0;
        dcnt[i]  = 0;
        we_cfg[i] = w;
        abase[i] = ab;
        wbase[i] = wb;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while ((rem[0] + rem[1] + rem[2] != 0 || dbus.gnt != 3'b000) && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_complete"}, 32'(n < budget), 32'd1);
        tick();
    endtask

    // Called right after tick(): reset lands mid-cycle, outputs must clear immediately.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt",   32'(dbus.gnt), 32'd0);
        chk("rst_ack",   32'(dbus.ack), 32'd0);
        chk("rst_err",   32'(dbus.err), 32'd0);
        chk("rst_breq",  32'(dbus.bus_req), 32'd0);
        chk("rst_bwe",   32'(dbus.bus_we), 32'd0);
        chk("rst_baddr", 32'(dbus.bus_addr), 32'd0);
        chk("rst_bwd",   32'(dbus.bus_wdata), 32'd0);
        chk("rst_rdata", 32'(dbus.rdata), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs();
    endtask

    // compare process: model prediction checked every cycle, then the model advances
    logic [2:0]    e_gnt, e_ack;
    logic          e_breq, e_done, e_err, e_stall, e_we, rel;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    int            o;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_owner  = -1;
            m_rr     = 0;
            m_served = 0;
            m_waited = 0;
            ack_seen = 3'b000;
            err_gnt  = 3'b000;
            gnt_prev = 3'b000;
            breq_prev = 1'b0;
            rsp_wait = 0;
            ccd_run  = 0;
            chk("rstc_gnt",   32'(dbus.gnt), 32'd0);
            chk("rstc_breq",  32'(dbus.bus_req), 32'd0);
            chk("rstc_stall", 32'(dbus.cpu_stall), 32'(dbus.req[0]));
        end else begin
            o       = (m_owner < 0) ? 0 : m_owner;
            e_gnt   = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            e_breq  = (m_owner >= 0) && dbus.req[o];
            e_done  = e_breq && dbus.bus_ready;
            e_err   = e_breq && !dbus.bus_ready && (m_waited == TO);
            e_ack   = e_done ? e_gnt : 3'b000;
            e_we    = e_breq && dbus.we[o];
            e_addr  = e_breq ? dbus.addr[o*AW +: AW] : '0;
            e_wdata = e_breq ? dbus.wdata[o*DW +: DW] : '0;
            e_rdata = e_done ? dbus.bus_rdata : '0;
            e_stall = dbus.req[0] && !e_ack[0];

            chk("gnt",       32'(dbus.gnt), 32'(e_gnt));
            chk("ack",       32'(dbus.ack), 32'(e_ack));
            chk("err",       32'(dbus.err), 32'(e_err));
            chk("bus_req",   32'(dbus.bus_req), 32'(e_breq));
            chk("bus_we",    32'(dbus.bus_we), 32'(e_we));
            chk("bus_addr",  32'(dbus.bus_addr), 32'(e_addr));
            chk("bus_wdata", 32'(dbus.bus_wdata), 32'(e_wdata));
            chk("rdata",     32'(dbus.rdata), 32'(e_rdata));
            chk("cpu_stall", 32'(dbus.cpu_stall), 32'(e_stall));

            ack_seen = dbus.ack;
            err_gnt  = dbus.err ? dbus.gnt : 3'b000;
            if (dbus.bus_req && !dbus.bus_ready) rsp_wait++;
            else rsp_wait = 0;
            if (dbus.bus_req && !breq_prev) breq_rise = cyc;
            if (dbus.err) begin
                err_cnt++;
                err_lat = cyc - breq_rise;
            end
            if (dbus.ack != 3'b000) ack_lat = cyc - breq_rise;
            if (gnt_prev == 3'b000 && dbus.gnt != 3'b000) begin
                grant_log.push_back(dbus.gnt[0] ? 0 : (dbus.gnt[1] ? 1 : 2));
                grant_cyc.push_back(cyc);
            end
            if (dbus.ack[1]) ccd_run++;
            if (gnt_prev[1] && !dbus.gnt[1]) begin
                ccd_runs.push_back(ccd_run);
                ccd_run = 0;
            end
            gnt_prev  = dbus.gnt;
            breq_prev = dbus.bus_req;

            if (m_owner < 0) begin
                if (dbus.req != 3'b000) begin
                    m_owner  = pick(m_rr, dbus.req);
                    m_served = 0;
                    m_waited = 0;
                end
            end else begin
                rel = 1'b0;
                if (e_done) begin
                    m_served++;
                    m_waited = 0;
                    if (dbus.last[o] || m_served == MB) rel = 1'b1;
                end else if (e_breq) begin
                    if (e_err) rel = 1'b1;
                    else m_waited++;
                end else begin
                    rel = 1'b1;
                end
                if (rel) begin
                    m_rr    = (o + 1) % 3;
                    m_owner = -1;
                end
            end
        end
    end

    int g0, r0, e0;
    int exp_seq[8];

    initial begin
        cyc = 0;
        err_cnt = 0;
        breq_rise = 0;
        err_lat = 0;
        ack_lat = 0;
        we_cfg = 3'b000;
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) setup(i, 0, 1, 1'b0, AW'(16'h1000 * (i + 1)), DW'(16'hC000 + 256 * i));
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs();
        tick();
        tick();

        // single CPU write, ready one cycle after bus_req
        rdy_mode = 2;
        setup(0, 1, 1, 1'b1, 16'h0040, 16'hBEEF);
        drive_inputs();
        #1;
        chk("t1_gnt_req_cycle", 32'(dbus.gnt), 32'd0);
        chk("t1_stall_pending", 32'(dbus.cpu_stall), 32'd1);
        tick(); #1;
        chk("t1_gnt",   32'(dbus.gnt), 32'b001);
        chk("t1_addr",  32'(dbus.bus_addr), 32'h0040);
        chk("t1_wdata", 32'(dbus.bus_wdata), 32'hBEEF);
        chk("t1_we",    32'(dbus.bus_we), 32'd1);
        chk("t1_noack", 32'(dbus.ack), 32'd0);
        tick(); #1;
        chk("t1_ack",   32'(dbus.ack), 32'b001);
        chk("t1_stall_ack", 32'(dbus.cpu_stall), 32'd0);
        tick(); #1;
        chk("t1_release", 32'(dbus.gnt), 32'd0);
        chk("t1_stall_done", 32'(dbus.cpu_stall), 32'd0);
        tick();

        // all three single-beat requests together after reset: 0,1,2,0
        do_reset();
        rdy_mode = 0;
        setup(0, 2, 1, 1'b0, 16'h0100, 16'h1111);
        setup(1, 1, 1, 1'b1, 16'h0200, 16'h2222);
        setup(2, 1, 1, 1'b0, 16'h0300, 16'h3333);
        g0 = grant_log.size();
        e0 = err_cnt;
        drive_inputs();
        drain("t2", 100);
        chk("t2_ngrants", 32'(grant_log.size() - g0), 32'd4);
        if (grant_log.size() - g0 >= 4) begin
            exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 0;
            for (int k = 0; k < 4; k++) chk("t2_order", 32'(grant_log[g0 + k]), 32'(exp_seq[k]));
            for (int k = 0; k < 3; k++) chk("t2_gap", 32'(grant_cyc[g0 + k + 1] - grant_cyc[g0 + k]), 32'd2);
        end
        chk("t2_no_err", 32'(err_cnt - e0), 32'd0);

        // CCD 40-beat burst against a single accelerator beat
        do_reset();
        setup(1, 40, 40, 1'b1, 16'h4000, 16'h0A00);
        setup(2, 1, 1, 1'b1, 16'h8000, 16'h0B00);
        g0 = grant_log.size();
        r0 = ccd_runs.size();
        drive_inputs();
        drain("t3", 200);
        chk("t3_ccd_beats", 32'(dcnt[1]), 32'd40);
        chk("t3_acc_beats", 32'(dcnt[2]), 32'd1);
        chk("t3_nruns", 32'(ccd_runs.size() - r0), 32'd3);
        if (ccd_runs.size() - r0 >= 3) begin
            exp_seq[0] = 16; exp_seq[1] = 16; exp_seq[2] = 8;
            for (int k = 0; k < 3; k++) chk("t3_run", 32'(ccd_runs[r0 + k]), 32'(exp_seq[k]));
        end
        if (grant_log.size() - g0 >= 4) begin
            exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 1; exp_seq[3] = 1;
            for (int k = 0; k < 4; k++) chk("t3_order", 32'(grant_log[g0 + k]), 32'(exp_seq[k]));
        end else begin
            chk("t3_ngrants", 32'(grant_log.size() - g0), 32'd4);
        end

        // accelerator read times out; CPU served afterwards
        do_reset();
        rdy_mode = 1;
        e0 = err_cnt;
        g0 = grant_log.size();
        setup(2, 1, 1, 1'b0, 16'h9000, 16'h0000);
        drive_inputs();
        tick(); tick(); tick();
        setup(0, 1, 1, 1'b1, 16'h0050, 16'h5555);
        drive_inputs();
        for (int n = 0; n < 400 && err_cnt == e0; n++) tick();
        chk("t4_err_once", 32'(err_cnt - e0), 32'd1);
        rdy_mode = 0;
        drive_inputs();
        drain("t4", 100);
        chk("t4_err_latency", 32'(err_lat), 32'd255);
        chk("t4_no_acc_ack", 32'(dcnt[2]), 32'd0);
        chk("t4_cpu_served", 32'(dcnt[0]), 32'd1);
        if (grant_log.size() - g0 >= 2) begin
            chk("t4_order0", 32'(grant_log[g0]), 32'd2);
            chk("t4_order1", 32'(grant_log[g0 + 1]), 32'd0);
        end else begin
            chk("t4_ngrants", 32'(grant_log.size() - g0), 32'd2);
        end

        // ready arrives exactly on the threshold cycle: ack wins over err
        do_reset();
        rdy_mode = 3;
        e0 = err_cnt;
        setup(2, 1, 1, 1'b0, 16'hA000, 16'h0000);
        drive_inputs();
        drain("t5", 400);
        chk("t5_no_err", 32'(err_cnt - e0), 32'd0);
        chk("t5_acked", 32'(dcnt[2]), 32'd1);
        chk("t5_ack_latency", 32'(ack_lat), 32'd255);

        // reset mid-burst: pointer advanced by a CPU beat, then CCD burst aborted
        rdy_mode = 0;
        setup(0, 1, 1, 1'b0, 16'h0060, 16'h0000);
        drive_inputs();
        drain("t6a", 50);
        setup(1, 10, 10, 1'b1, 16'h5000, 16'h0D00);
        drive_inputs();
        tick(); tick(); tick(); tick();
        chk("t6_in_burst", 32'(dbus.gnt), 32'b010);
        setup(0, 1, 1, 1'b0, 16'h0070, 16'h0000);
        g0 = grant_log.size();
        do_reset();
        drain("t6", 100);
        if (grant_log.size() - g0 >= 1) chk("t6_first_after_rst", 32'(grant_log[g0]), 32'd0);
        else chk("t6_ngrants", 32'(grant_log.size() - g0), 32'd1);

        // CPU and CCD both streaming single beats
        do_reset();
        setup(0, 3, 1, 1'b1, 16'h0080, 16'h7000);
        setup(1, 5, 1, 1'b1, 16'h6000, 16'h0E00);
        g0 = grant_log.size();
        drive_inputs();
        drain("t7", 100);
        chk("t7_ngrants", 32'(grant_log.size() - g0), 32'd8);
`ifdef DBUS_CPU_PRIORITY_EN
        exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 1;
        exp_seq[4] = 1; exp_seq[5] = 1; exp_seq[6] = 1; exp_seq[7] = 1;
`else
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
        exp_seq[4] = 0; exp_seq[5] = 1; exp_seq[6] = 1; exp_seq[7] = 1;
`endif
        if (grant_log.size() - g0 >= 8)
            for (int k = 0; k < 8; k++) chk("t7_order", 32'(grant_log[g0 + k]), 32'(exp_seq[k]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
